branch_predictor_gshare: RTL and testbench

Parametrised tag-checked saturating-counter branch predictor with optional global-history (gshare) indexing and an in-order queue of in-flight predictions. It sits beside the fetch stage. The fetch stage issues a prediction request per branch. Execute later resolves branches oldest-first through the update port. A misprediction repairs the speculative global history and squashes all younger in-flight predictions.

---
 rtl/branch_predictor_gshare_if.sv | 30 +++
 rtl/branch_predictor_gshare.sv | 164 ++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_if.sv
// Fetch/execute-side handshake bundle for the tag-checked branch predictor.
// The master drives requests and resolutions; the slave is the predictor.
interface branch_predictor_gshare_if #(
    parameter int QUEUE_DEPTH = 4
);
    localparam int OW = $clog2(QUEUE_DEPTH) + 1;

    logic          req_valid;
    logic [63:0]   req_ip;
    logic          req_ready;
    logic          pred_valid;
    logic          pred_taken;
    logic          upd_valid;
    logic          upd_taken;
    logic          mispredict;
    logic          upd_underflow;
    logic [OW-1:0] occupancy;

    modport master (
        output req_valid, req_ip, upd_valid, upd_taken,
        input  req_ready, pred_valid, pred_taken,
        input  mispredict, upd_underflow, occupancy
    );

    modport slave (
        input  req_valid, req_ip, upd_valid, upd_taken,
        output req_ready, pred_valid, pred_taken,
        output mispredict, upd_underflow, occupancy
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Tag-checked saturating-counter predictor with an in-order in-flight queue.
// Define GSHARE_EN to XOR the global history into the table index.
module branch_predictor_gshare #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 56,
    parameter int CTR_WIDTH   = 2,
    parameter int HIST_WIDTH  = 8,
    parameter int QUEUE_DEPTH = 4
) (
    input logic                       clk,
    input logic                       reset_n,
    branch_predictor_gshare_if.slave  bp
);
    localparam int NE = 1 << INDEX_WIDTH;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [CTR_WIDTH-1:0] CMAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] WT   = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] WNT  = WT - CTR_WIDTH'(1);

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] idx;
        logic [TAG_WIDTH-1:0]   tag;
        logic                   hit;
        logic                   pred;
`ifdef GSHARE_EN
        logic [HIST_WIDTH-1:0]  snap;
`endif
    } ent_t;

    logic [TAG_WIDTH-1:0] tag_q [NE];
    logic [CTR_WIDTH-1:0] ctr_q [NE];
    ent_t                 mem_q [QUEUE_DEPTH];

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic          pv_q, pt_q, mis_q, unf_q;

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   hit, pred;
    logic                   full, acc, pop, mis, push;
    ent_t                   head, ent_d;
    logic [CTR_WIDTH-1:0]   ctr_new;

`ifdef GSHARE_EN
    logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
    logic [HIST_WIDTH:0]   spec_sh, fix_sh;
`endif

    always_comb begin
        req_tag = bp.req_ip[63 -: TAG_WIDTH];
`ifdef GSHARE_EN
        idx = bp.req_ip[INDEX_WIDTH-1:0] ^ INDEX_WIDTH'(ghr_q);
`else
        idx = bp.req_ip[INDEX_WIDTH-1:0];
`endif
        hit  = (tag_q[idx] == req_tag);
        pred = hit & ctr_q[idx][CTR_WIDTH-1];

        full = (cnt_q == OW'(QUEUE_DEPTH));
        acc  = bp.req_valid & ~full;
        pop  = bp.upd_valid & (cnt_q != '0);
        head = mem_q[rd_q];
        mis  = pop & (head.pred != bp.upd_taken);
        // A mispredicting update squashes the request arriving with it
        push = acc & ~mis;

        ent_d      = '0;
        ent_d.idx  = idx;
        ent_d.tag  = req_tag;
        ent_d.hit  = hit;
        ent_d.pred = pred;
`ifdef GSHARE_EN
        ent_d.snap = ghr_q;
`endif

        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q + PW'(push);
        if (mis) begin
            cnt_d = '0;
            rd_d  = wr_q;
        end else begin
            cnt_d = cnt_q + OW'(push) - OW'(pop);
            rd_d  = rd_q + PW'(pop);
        end

        ctr_new = ctr_q[head.idx];
        if (head.hit) begin
            if (bp.upd_taken && ctr_new != CMAX)
                ctr_new = ctr_new + CTR_WIDTH'(1);
            else if (!bp.upd_taken && ctr_new != '0)
                ctr_new = ctr_new - CTR_WIDTH'(1);
        end else begin
            ctr_new = bp.upd_taken ? WT : WNT;
        end
    end

`ifdef GSHARE_EN
    always_comb begin
        spec_sh = {ghr_q, pred};
        fix_sh  = {head.snap, bp.upd_taken};
        ghr_d   = ghr_q;
        if (mis)
            ghr_d = fix_sh[HIST_WIDTH-1:0];
        else if (push)
            ghr_d = spec_sh[HIST_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NE; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= WT;
            end
        end else if (pop) begin
            ctr_q[head.idx] <= ctr_new;
            if (!head.hit)
                tag_q[head.idx] <= head.tag;
        end
    end

    // Payload needs no reset; only entries below cnt_q are ever read
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= ent_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            pv_q  <= 1'b0;
            pt_q  <= 1'b0;
            mis_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            pv_q  <= push;
            pt_q  <= push & pred;
            mis_q <= mis;
            unf_q <= bp.upd_valid & (cnt_q == '0);
        end
    end

    assign bp.req_ready     = ~full;
    assign bp.pred_valid    = pv_q;
    assign bp.pred_taken    = pt_q;
    assign bp.mispredict    = mis_q;
    assign bp.upd_underflow = unf_q;
    assign bp.occupancy     = cnt_q;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Randomized self-checking bench for branch_predictor_gshare against a
// queue/array reference model; honours GSHARE_EN like the design.
module tb_branch_predictor_gshare;
    localparam int IW = 8;
    localparam int TW = 56;
    localparam int CW = 2;
    localparam int HW = 8;
    localparam int QD = 4;
    localparam int NE = 1 << IW;
    localparam int HALF = 1 << (CW - 1);
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    branch_predictor_gshare_if #(.QUEUE_DEPTH(QD)) bp ();

    branch_predictor_gshare #(
        .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .CTR_WIDTH(CW),
        .HIST_WIDTH(HW), .QUEUE_DEPTH(QD)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bp(bp)
    );

    typedef struct {
        int            idx;
        logic [TW-1:0] tag;
        bit            hit;
        bit            pred;
        int            snap;
    } m_ent_t;

    m_ent_t        mq[$];
    logic [TW-1:0] m_tag [NE];
    int            m_ctr [NE];
    int            m_ghr;
    bit            e_pv, e_pt, e_mis, e_unf;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) begin
            m_tag[i] = '0;
            m_ctr[i] = HALF;
        end
        m_ghr = 0;
        mq.delete();
    endfunction

    task automatic model_step(bit rv, logic [63:0] ip, bit uv, bit ut);
        int     n, idx, snap;
        bit     hit, pred, acc, pop;
        m_ent_t e;
        n   = mq.size();
        acc = rv && (n < QD);
        pop = uv && (n > 0);
`ifdef GSHARE_EN
        idx = int'(ip[IW-1:0]) ^ m_ghr;
`else
        idx = int'(ip[IW-1:0]);
`endif
        hit   = (m_tag[idx] == ip[63:64-TW]);
        pred  = hit && (m_ctr[idx] >= HALF);
        snap  = m_ghr;
        e_mis = 1'b0;
        e_unf = uv && (n == 0);
        if (pop) begin
            e = mq.pop_front();
            if (e.hit) begin
                if (ut) m_ctr[e.idx] = (m_ctr[e.idx] + 1 > CMAX) ? CMAX : m_ctr[e.idx] + 1;
                else    m_ctr[e.idx] = (m_ctr[e.idx] - 1 < 0) ? 0 : m_ctr[e.idx] - 1;
            end else begin
                m_tag[e.idx] = e.tag;
                m_ctr[e.idx] = ut ? HALF : HALF - 1;
            end
            if (e.pred != ut) begin
                e_mis = 1'b1;
                m_ghr = ((e.snap << 1) | int'(ut)) & ((1 << HW) - 1);
                mq.delete();
            end
        end
        e_pv = acc && !e_mis;
        e_pt = pred;
        if (e_pv) begin
            mq.push_back('{idx, ip[63:64-TW], hit, pred, snap});
            m_ghr = ((snap << 1) | int'(pred)) & ((1 << HW) - 1);
        end
    endtask

    task automatic cyc(bit rv, logic [63:0] ip, bit uv, bit ut);
        bp.req_valid = rv;
        bp.req_ip    = ip;
        bp.upd_valid = uv;
        bp.upd_taken = ut;
        @(posedge clk);
        model_step(rv, ip, uv, ut);
        #1;
        check("pred_valid", bp.pred_valid, e_pv);
        if (e_pv) check("pred_taken", bp.pred_taken, e_pt);
        check("mispredict", bp.mispredict, e_mis);
        check("upd_underflow", bp.upd_underflow, e_unf);
        check("occupancy", bp.occupancy, mq.size());
        check("req_ready", bp.req_ready, mq.size() < QD);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_pv"}, bp.pred_valid, 0);
        check({tag, "_pt"}, bp.pred_taken, 0);
        check({tag, "_mis"}, bp.mispredict, 0);
        check({tag, "_unf"}, bp.upd_underflow, 0);
        check({tag, "_occ"}, bp.occupancy, 0);
        check({tag, "_rdy"}, bp.req_ready, 1);
    endtask

    task automatic async_reset();
        bp.req_valid = 1'b0;
        bp.upd_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    localparam logic [63:0] IPA = 64'h0000_0001_0000_0040;

    initial begin
        bit            t;
        logic [63:0]   ip;
        reset_n      = 1'b0;
        bp.req_valid = 1'b0;
        bp.req_ip    = '0;
        bp.upd_valid = 1'b0;
        bp.upd_taken = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        reset_n = 1'b1;

        // Tag miss predicts not-taken; a taken update then mispredicts
        cyc(1, IPA, 0, 0);
        check("miss_pred", bp.pred_taken, 0);
        cyc(0, '0, 1, 1);
        check("miss_update_mis", bp.mispredict, 1);
        cyc(1, IPA, 0, 0);
        cyc(0, '0, 1, 1);

        // Saturation up then down on the same address
        for (int i = 0; i < 5; i++) begin
            cyc(1, IPA, 0, 0);
            cyc(0, '0, 1, 1);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1, IPA, 0, 0);
            cyc(0, '0, 1, 0);
        end
        cyc(1, IPA, 0, 0);
        cyc(0, '0, 1, mq[0].pred);

        // Fill the queue, then one extra request
        for (int i = 0; i < 4; i++) cyc(1, IPA + 64'(i * 8), 0, 0);
        check("fill_occ", bp.occupancy, 4);
        check("fill_rdy", bp.req_ready, 0);
        cyc(1, IPA + 64'h100, 0, 0);
        check("full_reject", bp.pred_valid, 0);
        cyc(0, '0, 1, mq[0].pred);
        check("pop_occ", bp.occupancy, 3);
        check("pop_rdy", bp.req_ready, 1);

        // Mispredict with three queued entries and a simultaneous request
        t = !mq[0].pred;
        cyc(1, IPA + 64'h200, 1, t);
        check("flush_mis", bp.mispredict, 1);
        check("flush_occ", bp.occupancy, 0);
        check("flush_squash", bp.pred_valid, 0);

        // Update against an empty queue
        cyc(0, '0, 1, 0);
        check("underflow_pulse", bp.upd_underflow, 1);
        cyc(0, '0, 0, 0);
        check("underflow_clear", bp.upd_underflow, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            ip = {32'($urandom_range(0, 3)), 24'h0, 8'($urandom_range(0, 15) * 4)};
            if (mq.size() > 0 && $urandom_range(0, 9) < 7)
                t = ($urandom_range(0, 9) < 8) ? mq[0].pred : !mq[0].pred;
            else
                t = 1'($urandom);
            cyc($urandom_range(0, 9) < 7, ip, $urandom_range(0, 9) < 4, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
